// File: rtl/mod465_pkg.sv
// Shared types and constants for the 4-ASK receive decision path.
// Samples use a signed 1s17 format.
package mod465_pkg;

  localparam int unsigned DW = 18;

  localparam logic signed [DW-1:0] S_MAX = 18'sd131071;
  localparam logic signed [DW-1:0] S_MIN = -18'sd131072;

  localparam logic signed [DW-1:0] INIT_REF_DEFAULT = 18'sd32768;

  typedef enum logic [1:0] {
    SYM_M3 = 2'b00,
    SYM_M1 = 2'b01,
    SYM_P1 = 2'b11,
    SYM_P3 = 2'b10
  } sym_t;

endpackage

// File: rtl/sym_abs_avg.sv
// Captures |x| on each symbol strobe and averages it over blocks of 2^LOG2_N
// symbols to produce the slicer reference level.
module sym_abs_avg
  import mod465_pkg::*;
#(
  parameter int unsigned           LOG2_N   = 10,
  parameter logic signed [DW-1:0]  INIT_REF = INIT_REF_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_sym_en,
  input  logic signed [DW-1:0] i_in,
  input  logic                 i_cap_valid,
  output logic signed [DW-1:0] o_ref_level,
  output logic                 o_ref_valid
);

  localparam int unsigned AW = DW + LOG2_N;

  logic [DW-2:0]       w_abs;
  logic [AW-1:0]       w_sum;
  logic [DW-2:0]       r_abs;
  logic [AW-1:0]       r_acc;
  logic [LOG2_N-1:0]   r_cnt;
  logic signed [DW-1:0] r_ref_level;
  logic                r_ref_valid;

  // The most negative input has no positive twin, so it clamps to S_MAX.
  always_comb begin
    w_abs = i_in[DW-2:0];
    if (i_in == S_MIN) begin
      w_abs = S_MAX[DW-2:0];
    end else if (i_in[DW-1]) begin
      w_abs = (DW-1)'(-i_in);
    end
  end

  assign w_sum = r_acc + AW'(r_abs);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_abs       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ref_level <= INIT_REF;
      r_ref_valid <= 1'b0;
    end else begin
      r_ref_valid <= 1'b0;
      if (i_sym_en) begin
        r_abs <= w_abs;
      end
      if (i_cap_valid) begin
        if (r_cnt == '1) begin
          r_ref_level <= signed'(DW'(w_sum >> LOG2_N));
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ref_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_ref_level = r_ref_level;
  assign o_ref_valid = r_ref_valid;

endmodule

// File: rtl/ask4_slicer_ref.sv
// 4-ASK symbol slicer: Gray-coded decision and saturated slicer error against
// a block-averaged reference level (threshold = 2a).
module ask4_slicer_ref
  import mod465_pkg::*;
#(
  parameter int unsigned           LOG2_N   = 10,
  parameter logic signed [DW-1:0]  INIT_REF = INIT_REF_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_clk_en,
  input  logic signed [DW-1:0] in,
  output logic [1:0]           out_sym,
  output logic                 out_valid,
  output logic signed [DW-1:0] err,
  output logic signed [DW-1:0] ref_level,
  output logic                 ref_valid
);

  logic signed [DW-1:0] r_s;
  logic                 r_cap_valid;
  sym_t                 r_sym;
  logic signed [DW-1:0] r_err;
  logic                 r_out_valid;

  logic signed [DW-1:0] w_ref;
  logic signed [19:0]   w_s20;
  logic signed [19:0]   w_r20;
  logic signed [19:0]   w_half20;
  logic signed [19:0]   w_recon20;
  logic signed [19:0]   w_err20;
  sym_t                 w_sym;
  logic signed [DW-1:0] w_err;

  sym_abs_avg #(
    .LOG2_N   (LOG2_N),
    .INIT_REF (INIT_REF)
  ) u_avg (
    .clk         (clk),
    .reset       (reset),
    .i_sym_en    (sym_clk_en),
    .i_in        (in),
    .i_cap_valid (r_cap_valid),
    .o_ref_level (w_ref),
    .o_ref_valid (ref_valid)
  );

  // Slice with the reference held before this edge; a reload on the same
  // edge only affects later symbols.
  always_comb begin
    w_s20     = {{2{r_s[DW-1]}}, r_s};
    w_r20     = {{2{w_ref[DW-1]}}, w_ref};
    w_half20  = w_r20 >>> 1;
    w_sym     = SYM_M3;
    w_recon20 = -(w_r20 + w_half20);
    if (w_s20 >= w_r20) begin
      w_sym     = SYM_P3;
      w_recon20 = w_r20 + w_half20;
    end else if (w_s20 >= 20'sd0) begin
      w_sym     = SYM_P1;
      w_recon20 = w_half20;
    end else if (w_s20 >= -w_r20) begin
      w_sym     = SYM_M1;
      w_recon20 = -w_half20;
    end
    w_err20 = w_s20 - w_recon20;
    w_err   = w_err20[DW-1:0];
    if (w_err20 > 20'sd131071) begin
      w_err = S_MAX;
    end else if (w_err20 < -20'sd131072) begin
      w_err = S_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s         <= '0;
      r_cap_valid <= 1'b0;
      r_sym       <= SYM_M3;
      r_err       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_cap_valid <= sym_clk_en;
      if (sym_clk_en) begin
        r_s <= in;
      end
      r_out_valid <= r_cap_valid;
      if (r_cap_valid) begin
        r_sym <= w_sym;
        r_err <= w_err;
      end
    end
  end

  assign out_sym   = r_sym;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign ref_level = w_ref;

endmodule

// File: tb/tb_ask4_slicer_ref.sv
// Directed self-checking bench for ask4_slicer_ref with 4-symbol averaging blocks.
module tb_ask4_slicer_ref;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic signed [17:0] in_d = '0;
  logic [1:0]         out_sym;
  logic               out_valid;
  logic signed [17:0] err;
  logic signed [17:0] ref_level;
  logic               ref_valid;

  int n_checks = 0;
  int n_fail   = 0;

  ask4_slicer_ref #(
    .LOG2_N   (2),
    .INIT_REF (18'sd32768)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_clk_en (sym_clk_en),
    .in         (in_d),
    .out_sym    (out_sym),
    .out_valid  (out_valid),
    .err        (err),
    .ref_level  (ref_level),
    .ref_valid  (ref_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    sym_clk_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    // Strobe held high during reset must be ignored.
    @(negedge clk);
    reset = 1'b0;
    sym_clk_en = 1'b1;
    in_d = 18'sd50000;
    @(negedge clk);
    @(negedge clk);
    sym_clk_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle_valid: got %b expected 0 (cycle %0d)", out_valid, i);
      end
      n_checks++;
      if (ref_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle_refvalid: got %b expected 0 (cycle %0d)", ref_valid, i);
      end
    end
    n_checks++;
    if (ref_level !== 18'sd32768) begin
      n_fail++; $display("FAIL reset_ref: got %0d expected 32768", ref_level);
    end
    n_checks++;
    if (out_sym !== 2'b00) begin
      n_fail++; $display("FAIL reset_sym: got %b expected 00", out_sym);
    end
    n_checks++;
    if (err !== 18'sd0) begin
      n_fail++; $display("FAIL reset_err: got %0d expected 0", err);
    end
  endtask

  task automatic test_slice;
    int         v[4];
    logic [1:0] es[4];
    int         ee[4];
    v  = '{50000, 20000, -10000, -60000};
    es = '{2'b10, 2'b11, 2'b01, 2'b00};
    ee = '{848, 3616, 6384, -10848};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sym_clk_en = 1'b1;
      in_d = 18'(v[k]);
      @(negedge clk);
      sym_clk_en = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL slice_early_valid[%0d]: got %b expected 0", k, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL slice_valid[%0d]: got %b expected 1", k, out_valid);
      end
      n_checks++;
      if (out_sym !== es[k]) begin
        n_fail++; $display("FAIL slice_sym[%0d]: got %b expected %b", k, out_sym, es[k]);
      end
      n_checks++;
      if (err !== 18'(ee[k])) begin
        n_fail++; $display("FAIL slice_err[%0d]: got %0d expected %0d", k, err, ee[k]);
      end
      n_checks++;
      if (ref_valid !== (k == 3)) begin
        n_fail++; $display("FAIL slice_refvalid[%0d]: got %b expected %b", k, ref_valid, (k == 3));
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL slice_pulse_width[%0d]: got %b expected 0", k, out_valid);
      end
    end
    n_checks++;
    if (ref_level !== 18'sd35000) begin
      n_fail++; $display("FAIL slice_ref_update: got %0d expected 35000", ref_level);
    end
  endtask

  task automatic test_back_to_back;
    int v[5];
    int ee[5];
    v  = '{40000, 40000, 40000, 40000, 50000};
    ee = '{-9152, -9152, -9152, -9152, -10000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 7) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i - 2, out_valid);
        end
        n_checks++;
        if (out_sym !== 2'b10) begin
          n_fail++; $display("FAIL b2b_sym[%0d]: got %b expected 10", i - 2, out_sym);
        end
        n_checks++;
        if (err !== 18'(ee[i-2])) begin
          n_fail++; $display("FAIL b2b_err[%0d]: got %0d expected %0d", i - 2, err, ee[i-2]);
        end
        n_checks++;
        if (ref_valid !== (i == 5)) begin
          n_fail++; $display("FAIL b2b_refvalid[%0d]: got %b expected %b", i - 2, ref_valid, (i == 5));
        end
        n_checks++;
        if (ref_level !== ((i >= 5) ? 18'sd40000 : 18'sd32768)) begin
          n_fail++; $display("FAIL b2b_ref[%0d]: got %0d expected %0d", i - 2, ref_level,
                             (i >= 5) ? 40000 : 32768);
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_idle_valid[%0d]: got %b expected 0", i, out_valid);
        end
      end
      if (i < 5) begin
        sym_clk_en = 1'b1;
        in_d = 18'(v[i]);
      end else begin
        sym_clk_en = 1'b0;
      end
    end
  endtask

  task automatic test_saturation;
    int         v[6];
    logic [1:0] es[6];
    int         ee[6];
    v  = '{-131072, -131072, -131072, -131072, 131071, -131072};
    es = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    ee = '{-81920, -81920, -81920, -81920, -65535, 65534};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sym !== es[i-2]) begin
          n_fail++; $display("FAIL sat_sym[%0d]: got valid=%b sym=%b expected valid=1 sym=%b",
                             i - 2, out_valid, out_sym, es[i-2]);
        end
        n_checks++;
        if (err !== 18'(ee[i-2])) begin
          n_fail++; $display("FAIL sat_err[%0d]: got %0d expected %0d", i - 2, err, ee[i-2]);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (ref_level !== 18'sd131071) begin
          n_fail++; $display("FAIL sat_ref: got %0d expected 131071", ref_level);
        end
      end
      if (i < 6) begin
        sym_clk_en = 1'b1;
        in_d = 18'(v[i]);
      end else begin
        sym_clk_en = 1'b0;
      end
    end
  endtask

  task automatic test_zero_ref;
    int         v[7];
    logic [1:0] es[7];
    int         ee[7];
    v  = '{0, 0, 0, 0, 0, -1, 5};
    es = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10};
    ee = '{-16384, -16384, -16384, -16384, 0, -1, 5};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sym !== es[i-2]) begin
          n_fail++; $display("FAIL zero_sym[%0d]: got valid=%b sym=%b expected valid=1 sym=%b",
                             i - 2, out_valid, out_sym, es[i-2]);
        end
        n_checks++;
        if (err !== 18'(ee[i-2])) begin
          n_fail++; $display("FAIL zero_err[%0d]: got %0d expected %0d", i - 2, err, ee[i-2]);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (ref_level !== 18'sd0) begin
          n_fail++; $display("FAIL zero_ref: got %0d expected 0", ref_level);
        end
      end
      if (i < 7) begin
        sym_clk_en = 1'b1;
        in_d = 18'(v[i]);
      end else begin
        sym_clk_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_block;
    do_reset();
    @(negedge clk);
    sym_clk_en = 1'b1;
    in_d = 18'sd40000;
    @(negedge clk);
    @(negedge clk);
    sym_clk_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_first_valid: got %b expected 1", out_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_inflight_dropped: got %b expected 0", out_valid);
    end
    n_checks++;
    if (ref_level !== 18'sd32768) begin
      n_fail++; $display("FAIL midrst_ref_restore: got %0d expected 32768", ref_level);
    end
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (ref_valid !== (i == 5)) begin
        n_fail++; $display("FAIL midrst_refvalid[%0d]: got %b expected %b", i, ref_valid, (i == 5));
      end
      if (i >= 2 && i < 6) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sym !== 2'b11 || err !== -18'sd8384) begin
          n_fail++; $display("FAIL midrst_slice[%0d]: got valid=%b sym=%b err=%0d expected valid=1 sym=11 err=-8384",
                             i - 2, out_valid, out_sym, err);
        end
      end
      if (i < 4) begin
        sym_clk_en = 1'b1;
        in_d = 18'sd8000;
      end else begin
        sym_clk_en = 1'b0;
      end
    end
    n_checks++;
    if (ref_level !== 18'sd8000) begin
      n_fail++; $display("FAIL midrst_ref: got %0d expected 8000", ref_level);
    end
  endtask

  task automatic test_gap;
    int v[8];
    int means[2];
    int n_valid;
    v     = '{1000, -3000, 5000, -7001, 100000, -131072, 2, -3};
    means = '{4000, 57769};
    n_valid = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sym_clk_en = 1'b1;
      in_d = 18'(v[k]);
      for (int c = 1; c < 7; c++) begin
        @(negedge clk);
        sym_clk_en = 1'b0;
        if (out_valid === 1'b1) n_valid++;
        if (c == 2) begin
          n_checks++;
          if (ref_valid !== ((k % 4) == 3)) begin
            n_fail++; $display("FAIL gap_refvalid[%0d]: got %b expected %b", k, ref_valid, ((k % 4) == 3));
          end
          if ((k % 4) == 3) begin
            n_checks++;
            if (ref_level !== 18'(means[k/4])) begin
              n_fail++; $display("FAIL gap_ref[%0d]: got %0d expected %0d", k / 4, ref_level, means[k/4]);
            end
          end
        end
      end
    end
    n_checks++;
    if (n_valid != 8) begin
      n_fail++; $display("FAIL gap_valid_count: got %0d expected 8", n_valid);
    end
  endtask

  initial begin
    test_reset();
    test_slice();
    test_back_to_back();
    test_saturation();
    test_zero_ref();
    test_reset_mid_block();
    test_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
